// File: rtl/param_comm_controller.sv
// Host-link controller: parses N_CH x DATA_BYTES write frames and read requests from a UART byte link.
// Define COMM_CHECKSUM_EN to add an XOR frame checksum in both directions.
module param_comm_controller #(
    parameter int N_CH           = 2,
    parameter int DATA_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 120000,
    localparam int W             = 8 * DATA_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_ready,
    input  logic              tx_busy,
    input  logic [N_CH*W-1:0] weights,
    input  logic [W-1:0]      result,
    output logic [7:0]        tx_byte,
    output logic              tx_send,
    output logic              rx_clear,
    output logic [N_CH*W-1:0] weights_new,
    output logic [N_CH*W-1:0] inputs_new,
    output logic              weight_write,
    output logic              input_write,
    output logic [7:0]        err_count,
    output logic [3:0]        ctrl_state
);
    localparam int P = N_CH * DATA_BYTES;
`ifdef COMM_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int RX_TOTAL = P + CS;
    localparam int TX_TOTAL = 1 + P + DATA_BYTES + CS;
    localparam int RCW = $clog2(RX_TOTAL + 1);
    localparam int TCW = $clog2(TX_TOTAL + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_READ = 8'd5,   OP_WR_W = 8'd50, OP_WR_I = 8'd51;
    localparam logic [7:0] OP_RSP  = 8'd100, OP_OK   = 8'd101, OP_ERR = 8'd102;

    typedef enum logic [3:0] {
        IDLE, RX_WAIT, RX_REG, RX_CHECK, TX_RESP, TX_LOAD, TX_SEND, TX_GAP
    } state_t;

    state_t                state, state_nx;
    logic [7:0]            opcode, rx_xor, tx_xor;
    logic [RCW-1:0]        rx_cnt, rx_idx;
    logic [TOW-1:0]        to_cnt;
    logic [TCW-1:0]        tx_cnt;
    logic [N_CH*W-1:0]     shadow;
    logic [TX_TOTAL*8-1:0] tx_snap;
    logic                  csum_bad, resp_ok, take, rx_seen, cs_last;

    // Byte position of payload byte i: channels in order, each value MSB first.
    function automatic int slot(input int i);
        return (i / DATA_BYTES) * DATA_BYTES + (DATA_BYTES - 1 - i % DATA_BYTES);
    endfunction

    // rx_clear is registered, so rx_ready is still high in the clear cycle; mask it.
    assign rx_seen    = rx_ready & ~rx_clear;
    assign rx_idx     = RCW'(RX_TOTAL) - rx_cnt;
    assign ctrl_state = state;
`ifdef COMM_CHECKSUM_EN
    assign cs_last = (tx_cnt == TCW'(1));
`else
    assign cs_last = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        take         = 1'b0;
        tx_send      = 1'b0;
        tx_byte      = 8'd0;
        weight_write = 1'b0;
        input_write  = 1'b0;
        case (state)
            IDLE: if (rx_seen) begin
                take = 1'b1;
                if (rx_byte == OP_WR_W || rx_byte == OP_WR_I) state_nx = RX_WAIT;
                else if (rx_byte == OP_READ)                  state_nx = TX_LOAD;
            end
            RX_WAIT: begin
                if (rx_seen) begin
                    take     = 1'b1;
                    state_nx = RX_REG;
                end else if (to_cnt == TOW'(TIMEOUT_CYCLES)) begin
                    state_nx = TX_RESP;
                end
            end
            RX_REG:   state_nx = (rx_cnt == RCW'(1)) ? RX_CHECK : RX_WAIT;
            RX_CHECK: state_nx = TX_RESP;
            TX_RESP: if (!tx_busy) begin
                tx_send      = 1'b1;
                tx_byte      = resp_ok ? OP_OK : OP_ERR;
                weight_write = resp_ok && (opcode == OP_WR_W);
                input_write  = resp_ok && (opcode == OP_WR_I);
                state_nx     = IDLE;
            end
            TX_LOAD: state_nx = TX_SEND;
            TX_SEND: if (!tx_busy) begin
                tx_send  = 1'b1;
                tx_byte  = cs_last ? tx_xor : tx_snap[TX_TOTAL*8-1 -: 8];
                state_nx = TX_GAP;
            end
            TX_GAP:  state_nx = (tx_cnt != '0) ? TX_SEND : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_clear    <= 1'b0;
            opcode      <= '0;
            rx_cnt      <= '0;
            to_cnt      <= '0;
            rx_xor      <= '0;
            csum_bad    <= 1'b0;
            resp_ok     <= 1'b0;
            shadow      <= '0;
            tx_cnt      <= '0;
            tx_snap     <= '0;
            tx_xor      <= '0;
            weights_new <= '0;
            inputs_new  <= '0;
            err_count   <= '0;
        end else begin
            state    <= state_nx;
            rx_clear <= take;
            case (state)
                IDLE: if (rx_seen && (rx_byte == OP_WR_W || rx_byte == OP_WR_I)) begin
                    opcode   <= rx_byte;
                    rx_cnt   <= RCW'(RX_TOTAL);
                    to_cnt   <= '0;
                    rx_xor   <= rx_byte;
                    csum_bad <= 1'b0;
                    resp_ok  <= 1'b1;
                end
                RX_WAIT: if (!rx_seen) begin
                    if (to_cnt == TOW'(TIMEOUT_CYCLES)) resp_ok <= 1'b0;
                    else                                to_cnt  <= to_cnt + 1'b1;
                end
                RX_REG: begin
                    to_cnt <= '0;
                    rx_cnt <= rx_cnt - 1'b1;
                    rx_xor <= rx_xor ^ rx_byte;
                    for (int i = 0; i < P; i++)
                        if (rx_idx == RCW'(i)) shadow[slot(i)*8 +: 8] <= rx_byte;
                    if (rx_idx == RCW'(P)) csum_bad <= (rx_byte != rx_xor);
                end
                RX_CHECK: begin
                    if (csum_bad)                resp_ok     <= 1'b0;
                    else if (opcode == OP_WR_W)  weights_new <= shadow;
                    else                         inputs_new  <= shadow;
                end
                TX_RESP: if (!tx_busy && !resp_ok && err_count != 8'hFF)
                    err_count <= err_count + 1'b1;
                TX_LOAD: begin
                    tx_snap <= '0;
                    tx_snap[TX_TOTAL*8-1 -: 8] <= OP_RSP;
                    for (int i = 0; i < P; i++)
                        tx_snap[(TX_TOTAL-2-i)*8 +: 8] <= weights[slot(i)*8 +: 8];
                    for (int b = 0; b < DATA_BYTES; b++)
                        tx_snap[(TX_TOTAL-2-P-b)*8 +: 8] <= result[(DATA_BYTES-1-b)*8 +: 8];
                    tx_cnt <= TCW'(TX_TOTAL);
                    tx_xor <= '0;
                end
                TX_SEND: if (!tx_busy) begin
                    tx_snap <= tx_snap << 8;
                    tx_cnt  <= tx_cnt - 1'b1;
                    tx_xor  <= tx_xor ^ tx_byte;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_param_comm_controller.sv
// Directed bench for param_comm_controller: a 2-channel and a 3-channel instance on a shared clock.
module tb_param_comm_controller;
    localparam int TO = 40;
`ifdef COMM_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  rx_byte_a, tx_byte_a, err_count_a;
    logic        rx_ready_a, tx_busy_a, tx_send_a, rx_clear_a, weight_write_a, input_write_a;
    logic [31:0] weights_a, weights_new_a, inputs_new_a;
    logic [15:0] result_a;
    logic [3:0]  ctrl_state_a;

    logic [7:0]  rx_byte_b, tx_byte_b, err_count_b;
    logic        rx_ready_b, tx_busy_b, tx_send_b, rx_clear_b, weight_write_b, input_write_b;
    logic [47:0] weights_b, weights_new_b, inputs_new_b;
    logic [15:0] result_b;
    logic [3:0]  ctrl_state_b;

    param_comm_controller #(.N_CH(2), .DATA_BYTES(2), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte_a), .rx_ready(rx_ready_a), .tx_busy(tx_busy_a),
        .weights(weights_a), .result(result_a), .tx_byte(tx_byte_a), .tx_send(tx_send_a),
        .rx_clear(rx_clear_a), .weights_new(weights_new_a), .inputs_new(inputs_new_a),
        .weight_write(weight_write_a), .input_write(input_write_a), .err_count(err_count_a),
        .ctrl_state(ctrl_state_a));

    param_comm_controller #(.N_CH(3), .DATA_BYTES(2), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte_b), .rx_ready(rx_ready_b), .tx_busy(tx_busy_b),
        .weights(weights_b), .result(result_b), .tx_byte(tx_byte_b), .tx_send(tx_send_b),
        .rx_clear(rx_clear_b), .weights_new(weights_new_b), .inputs_new(inputs_new_b),
        .weight_write(weight_write_b), .input_write(input_write_b), .err_count(err_count_b),
        .ctrl_state(ctrl_state_b));

    int checks = 0, errors = 0;
    int busy_a_left = 0, busy_b_left = 0, viol_a = 0, viol_b = 0;
    int ww_cnt = 0, iw_cnt = 0, nw_viol = 0, exp_err = 0;
    logic [7:0]  q_a[$], q_b[$];
    logic [7:0]  exp_a [0:7];
    logic [7:0]  exp_b [0:9];
    logic [31:0] wn_prev, in_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART receiver model: hold rx_ready until rx_clear, drop it one edge later.
    task automatic host_byte(input bit sel, input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        if (sel) begin rx_byte_b = b; rx_ready_b = 1'b1; end
        else     begin rx_byte_a = b; rx_ready_a = 1'b1; end
        while ((sel ? rx_clear_b : rx_clear_a) !== 1'b1 && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk("rx_clear_wait", 64'(k < 200), 64'd1);
        @(posedge clk); #1;
        if (sel) rx_ready_b = 1'b0; else rx_ready_a = 1'b0;
    endtask

    task automatic wait_q(input bit sel, input int n, input int budget, input string tag);
        int k = 0;
        while ((sel ? q_b.size() : q_a.size()) < n && k < budget) begin
            @(negedge clk); k++;
        end
        chk(tag, 64'(sel ? q_b.size() : q_a.size()), 64'(n));
    endtask

    // Transmit monitor and UART transmitter busy model (busy for 3 clocks after each send).
    initial forever begin
        @(negedge clk);
        if (tx_send_a) begin q_a.push_back(tx_byte_a); if (tx_busy_a) viol_a++; busy_a_left = 3; end
        if (tx_send_b) begin q_b.push_back(tx_byte_b); if (tx_busy_b) viol_b++; busy_b_left = 3; end
        if (weight_write_a) ww_cnt++;
        if (input_write_a)  iw_cnt++;
        if (rst_n && ((weights_new_a !== wn_prev && !weight_write_a) ||
                      (inputs_new_a  !== in_prev && !input_write_a))) nw_viol++;
        wn_prev = weights_new_a;
        in_prev = inputs_new_a;
    end

    initial begin
        tx_busy_a = 1'b0;
        tx_busy_b = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_busy_a = (busy_a_left > 0); if (busy_a_left > 0) busy_a_left--;
            tx_busy_b = (busy_b_left > 0); if (busy_b_left > 0) busy_b_left--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rx_byte_a = '0; rx_ready_a = 1'b0; weights_a = 32'h5678_9ABC; result_a = 16'h4321;
        rx_byte_b = '0; rx_ready_b = 1'b0; weights_b = 48'h0003_0002_0001; result_b = 16'h00FF;
        exp_a = '{8'h64, 8'h9A, 8'hBC, 8'h56, 8'h78, 8'h43, 8'h21, 8'h0E};
        exp_b = '{8'h64, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'hFF, 8'h9B};
        repeat (3) @(negedge clk);
        chk("rst_tx_send", tx_send_a, 0);
        chk("rst_tx_byte", tx_byte_a, 0);
        chk("rst_rx_clear", rx_clear_a, 0);
        chk("rst_weights_new", weights_new_a, 0);
        chk("rst_inputs_new", inputs_new_a, 0);
        chk("rst_weight_write", weight_write_a, 0);
        chk("rst_input_write", input_write_a, 0);
        chk("rst_err_count", err_count_a, 0);
        chk("rst_state", ctrl_state_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write weights: OK exactly 2 clocks after the last byte is registered.
        host_byte(0, 8'd50); host_byte(0, 8'h12); host_byte(0, 8'h34);
        host_byte(0, 8'hAB); host_byte(0, 8'hCD);
        @(negedge clk);
        chk("ok_early", tx_send_a, 0);
        @(negedge clk);
        chk("ok_send", tx_send_a, 1);
        chk("ok_byte", tx_byte_a, 101);
        chk("ww_pulse", weight_write_a, 1);
        chk("weights_new", weights_new_a, 32'hABCD_1234);
        repeat (6) @(negedge clk);
        chk("ww_cnt", ww_cnt, 1);
        chk("iw_cnt_none", iw_cnt, 0);
        chk("idle_after_ok", ctrl_state_a, 0);

        // Write inputs.
        q_a.delete();
        host_byte(0, 8'd51); host_byte(0, 8'h01); host_byte(0, 8'h02);
        host_byte(0, 8'h03); host_byte(0, 8'h04);
`ifdef COMM_CHECKSUM_EN
        host_byte(0, 8'h37);
`endif
        wait_q(0, 1, 20, "in_resp_len");
        chk("in_resp", q_a[0], 101);
        repeat (2) @(negedge clk);
        chk("inputs_new", inputs_new_a, 32'h0304_0102);
        chk("iw_cnt", iw_cnt, 1);
`ifdef COMM_CHECKSUM_EN
        q_a.delete();
        host_byte(0, 8'd51); host_byte(0, 8'h05); host_byte(0, 8'h06);
        host_byte(0, 8'h07); host_byte(0, 8'h08); host_byte(0, 8'h00);
        wait_q(0, 1, 20, "cs_bad_len");
        chk("cs_bad_resp", q_a[0], 102);
        repeat (2) @(negedge clk);
        exp_err++;
        chk("cs_bad_iw_cnt", iw_cnt, 1);
        chk("cs_bad_inputs", inputs_new_a, 32'h0304_0102);
        chk("cs_bad_err", err_count_a, 64'(exp_err));
`endif

        // Inter-byte timeout mid-payload.
        q_a.delete();
        host_byte(0, 8'd51); host_byte(0, 8'hAA); host_byte(0, 8'hBB);
        repeat (TO / 2) @(negedge clk);
        chk("to_early", q_a.size(), 0);
        wait_q(0, 1, TO + 10, "to_resp_len");
        chk("to_resp", q_a[0], 102);
        repeat (2) @(negedge clk);
        exp_err++;
        chk("to_iw_cnt", iw_cnt, 1);
        chk("to_inputs", inputs_new_a, 32'h0304_0102);
        chk("to_err", err_count_a, 64'(exp_err));

        // Unknown opcode is cleared and ignored, then a read with a mid-reply input change.
        q_a.delete();
        host_byte(0, 8'd7);
        repeat (4) @(negedge clk);
        chk("op7_silent", q_a.size(), 0);
        chk("op7_idle", ctrl_state_a, 0);
        chk("op7_err", err_count_a, 64'(exp_err));
        host_byte(0, 8'd5);
        wait_q(0, 1, 20, "rd_first");
        weights_a = 32'hFFFF_FFFF;
        result_a  = 16'h0000;
        wait_q(0, 7 + CS, 100, "rd_len");
        for (int i = 0; i < 7 + CS; i++) chk($sformatf("rd_a_byte%0d", i), q_a[i], exp_a[i]);
        chk("busy_viol_a", viol_a, 0);
        repeat (4) @(negedge clk);
        chk("rd_idle", ctrl_state_a, 0);
        chk("rd_extra", q_a.size(), 64'(7 + CS));

        // Three-channel read.
        host_byte(1, 8'd5);
        wait_q(1, 9 + CS, 200, "rd_b_len");
        for (int i = 0; i < 9 + CS; i++) chk($sformatf("rd_b_byte%0d", i), q_b[i], exp_b[i]);
        chk("busy_viol_b", viol_b, 0);
        chk("commit_only_on_pulse", nw_viol, 0);

        // Reset mid-payload.
        q_a.delete();
        host_byte(0, 8'd50); host_byte(0, 8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", ctrl_state_a, 0);
        chk("mid_rst_tx_send", tx_send_a, 0);
        chk("mid_rst_rx_clear", rx_clear_a, 0);
        chk("mid_rst_ww", weight_write_a, 0);
        chk("mid_rst_weights_new", weights_new_a, 0);
        chk("mid_rst_inputs_new", inputs_new_a, 0);
        chk("mid_rst_err", err_count_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_silent", q_a.size(), 0);
        chk("post_rst_ww_cnt", ww_cnt, 1);
        chk("post_rst_idle", ctrl_state_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_comm_controller.md
# param_comm_controller

Parametrised host-link controller for the perceptron array. It sits between the UART byte interface and the neuron datapath, and replaces the fixed two-weight controller with one that handles N channels of configurable byte width. It adds three things the fixed controller lacks: an inter-byte receive timeout, an error response, and an optional frame checksum. It parses write-weights, write-inputs and read frames, commits payloads atomically, and streams state back to the host.

## Interface
- `N_CH`, default 2: number of weight/input channels (1..16).
- `DATA_BYTES`, default 2: bytes per value. `W` = 8*`DATA_BYTES`.
- `TIMEOUT_CYCLES`, default 120000: idle clocks allowed between received frame bytes (10 ms at 12 MHz).
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `rx_byte`  in  8: byte from the UART receiver.
- `rx_ready`  in  1: `rx_byte` is valid; held high until `rx_clear`.
- `tx_busy`  in  1: UART transmitter is busy.
- `weights`  in  N_CH*W: current weights; channel 0 is in the LSBs.
- `result`  in  W: perceptron output.
- `tx_byte`  out  8: byte to transmit.
- `tx_send`  out  1: one-cycle transmit strobe.
- `rx_clear`  out  1: one-cycle acknowledge of `rx_ready`.
- `weights_new`  out  N_CH*W: committed weight payload (registered).
- `inputs_new`  out  N_CH*W: committed input payload (registered).
- `weight_write`  out  1: one-cycle pulse; `weights_new` is valid.
- `input_write`  out  1: one-cycle pulse; `inputs_new` is valid.
- `err_count`  out  8: saturating count of error responses.
- `ctrl_state`  out  4: state encoding, for debug.

## Operation
Opcodes:
- 5 = read; 50 = write weights; 51 = write inputs.
- 100 = read response; 101 = OK; 102 = ERR.
- Any other opcode received in IDLE: pulse `rx_clear`, stay in IDLE.

Write frame:
- Opcode, then `P` = N_CH*DATA_BYTES payload bytes.
- Channel 0 first; each value is sent MSB first.
- Payload bytes fill a shadow buffer, indexed by a down-counter of width clog2(P+1).

Read frame:
- Host sends opcode 5.
- Block replies: 100, then weights channel 0..N_CH-1 (MSB first), then `result` (MSB first).
- `weights` and `result` are sampled into a TX snapshot register on entry to TX_LOAD, so the reply is coherent.

States:
- IDLE:
  - On `rx_ready` with opcode 50/51: latch opcode, pulse `rx_clear`, go to RX_WAIT.
  - On `rx_ready` with opcode 5: pulse `rx_clear`, go to TX_LOAD.
- RX_WAIT: on `rx_ready` go to RX_REG. If the timeout counter reaches `TIMEOUT_CYCLES`, go to TX_RESP with ERR.
- RX_REG: store the byte, pulse `rx_clear`, reload the timeout counter, decrement the byte counter. When the count is exhausted go to RX_CHECK; otherwise go to RX_WAIT.
- RX_CHECK:
  - If the frame is valid, copy the shadow buffer to `weights_new` or `inputs_new`, then go to TX_RESP with OK.
  - Otherwise go to TX_RESP with ERR.
- TX_RESP:
  - Waits for `tx_busy`=0, then drives `tx_send` with 101 or 102.
  - On OK, pulses `weight_write` or `input_write` in the same cycle.
  - On ERR, increments `err_count` (saturating at 255).
  - Then goes to IDLE.
- TX_LOAD: snapshot `weights` and `result`, load the TX counter, go to TX_SEND.
- TX_SEND: when `tx_busy`=0, drive `tx_send` with the current byte, then go to TX_GAP.
- TX_GAP: one cycle in which `tx_busy` is ignored. Go to TX_SEND if bytes remain, else IDLE.

Boundary conditions:
- `rx_ready` during any TX state is neither consumed nor cleared; it is handled from IDLE.
- Timeout or error: the shadow buffer is discarded and the committed outputs are unchanged.
- Reset mid-frame: return to IDLE with no strobe.
- `weights_new`/`inputs_new` change only in the cycle the matching write pulse is high.

## Timing
- Reset values: every output is 0, `ctrl_state` = IDLE, and both committed payload registers are 0.
- `rx_clear` is asserted in the cycle after `rx_ready` is first seen.
- Each received byte costs 2 clocks (RX_WAIT→RX_REG).
- OK/ERR `tx_send` appears 2 clocks after the last payload byte is registered, provided `tx_busy`=0.
- Consecutive TX bytes are at least 2 clocks apart; the UART must assert `tx_busy` in the cycle after `tx_send`.
- The timeout counter runs only in RX_WAIT. It is reloaded on entry from IDLE and in every RX_REG.

## Configuration
- `COMM_CHECKSUM_EN` defined:
  - Write frames carry one extra byte: the XOR of the opcode and all payload bytes. A mismatch produces ERR.
  - Read replies append the XOR of all bytes sent, including the leading 100.
- Not defined: no checksum byte in either direction. RX_CHECK always passes unless a timeout occurred.

## Test plan
- Default parameters, no checksum; host sends 50, 0x12, 0x34, 0xAB, 0xCD. Required: `weight_write` pulses once, `weights_new` = 0xABCD_1234, `tx_byte` = 101.
- `N_CH`=3; `weights`=0x0003_0002_0001, `result`=0x00FF; host sends 5. Required: 100, 00,01, 00,02, 00,03, 00,FF, each sent only while `tx_busy`=0.
- Host sends 51 and 2 bytes, then is silent for `TIMEOUT_CYCLES`+1 clocks. Required: 102 sent, no `input_write`, `inputs_new` unchanged, `err_count`=1.
- `COMM_CHECKSUM_EN`; host sends 51, 01, 02, 03, 04, 0x37 (correct). Required: 101 and `input_write`. The same frame with checksum 0x00 gives 102 and no strobe.
- Host sends opcode 7, then 5. Required: 7 is cleared and ignored, then a normal read reply. Asserting `rst_n` low mid-payload returns IDLE with all outputs 0.
